riscv_slave_port_arb: RTL and testbench

- Next-generation AHB-Lite slave-port arbiter for the MPSoC bus matrix. One instance sits in front of each bus slave.
- Selects one of MASTERS requesting master ports and muxes its address/control onto the slave. Write data is muxed with a one-data-phase delay.
- Adds the following beyond the previous generation:
  - parametrised priority width
  - selectable arbitration mode
  - HMASTLOCK-protected switching
  - SEQ-to-NONSEQ conversion on master switch
  - starvation ageing with per-master wait counters

---
 rtl/riscv_slave_port_arb.sv | 182 ++++++++++++++++++
 tb/tb_riscv_slave_port_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_slave_port_arb.sv
// AHB-Lite slave-port arbiter: one instance sits in front of each bus-matrix
// slave and selects one of MASTERS requesting ports.
//   HCLK/HRESETn        clock, async active-low reset
//   mst*                per-master address/control/write-data inputs (packed
//                       [MASTERS-1:0][...]), plus mstpriority and can_switch
//   mstHRDATA/READYOUT/RESP  slave response fanned back to all masters
//   slv_*               muxed address/control (grant index) and HWDATA
//                       (data-phase index), slave response inputs
//   granted_master      one-hot current grant
//   starved             per-master wait counter has hit STARVE_LIMIT

// Per-master wait counter: saturates at LIMIT, cleared while granted or idle.
module riscv_slave_port_arb_wcnt #(
  parameter int LIMIT = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic clr,
  input  logic inc,
  output logic starved
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                              cnt_d = '0;
    else if (inc && cnt_q != CW'(LIMIT))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign starved = (cnt_q == CW'(LIMIT));
endmodule

module riscv_slave_port_arb #(
  parameter int PLEN         = 64,
  parameter int XLEN         = 64,
  parameter int MASTERS      = 3,
  parameter int PRIO_BITS    = 3,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic [MASTERS-1:0][PRIO_BITS-1:0]   mstpriority,
  input  logic [MASTERS-1:0]                  mstHSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]        mstHADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]        mstHWDATA,
  output logic [XLEN-1:0]                     mstHRDATA,
  input  logic [MASTERS-1:0]                  mstHWRITE,
  input  logic [MASTERS-1:0][2:0]             mstHSIZE,
  input  logic [MASTERS-1:0][2:0]             mstHBURST,
  input  logic [MASTERS-1:0][3:0]             mstHPROT,
  input  logic [MASTERS-1:0][1:0]             mstHTRANS,
  input  logic [MASTERS-1:0]                  mstHMASTLOCK,
  input  logic [MASTERS-1:0]                  mstHREADY,
  output logic                                mstHREADYOUT,
  output logic                                mstHRESP,
  output logic                                slv_HSEL,
  output logic [PLEN-1:0]                     slv_HADDR,
  output logic [XLEN-1:0]                     slv_HWDATA,
  input  logic [XLEN-1:0]                     slv_HRDATA,
  output logic                                slv_HWRITE,
  output logic [2:0]                          slv_HSIZE,
  output logic [2:0]                          slv_HBURST,
  output logic [3:0]                          slv_HPROT,
  output logic [1:0]                          slv_HTRANS,
  output logic                                slv_HMASTLOCK,
  output logic                                slv_HREADYOUT,
  input  logic                                slv_HREADY,
  input  logic                                slv_HRESP,
  input  logic [MASTERS-1:0]                  can_switch,
  output logic [MASTERS-1:0]                  granted_master,
  output logic [MASTERS-1:0]                  starved
);
  localparam int IW   = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int NLVL = 1 << PRIO_BITS;

  logic [IW-1:0]                   grant_idx_q, grant_idx_d;
  logic [IW-1:0]                   dph_idx_q, dph_idx_d;
  logic [MASTERS-1:0]              granted_q, granted_d;
  logic [NLVL-1:0][IW-1:0]         ptr_q, ptr_d;
  logic                            fb_q, fb_d;

  logic [MASTERS-1:0][PRIO_BITS-1:0] eff;
  logic [PRIO_BITS-1:0]            lvl;
  logic [MASTERS-1:0]              cand;
  logic [IW-1:0]                   nxt_idx, scan;
  logic                            found, sw_en, take;
  logic [MASTERS-1:0]              wc_clr, wc_inc;
  logic [1:0]                      trans_mux;

  // Arbitration: highest effective level wins, round-robin inside the level
  // starting just after that level's last grant.
  always_comb begin
    lvl = '0;
    for (int n = 0; n < MASTERS; n++) begin
      eff[n] = starved[n] ? '1 : ((ARB_MODE == 1) ? '0 : mstpriority[n]);
      if (mstHSEL[n] && eff[n] > lvl) lvl = eff[n];
    end
    for (int n = 0; n < MASTERS; n++)
      cand[n] = mstHSEL[n] && (eff[n] == lvl);
    nxt_idx = grant_idx_q;
    found   = 1'b0;
    scan    = ptr_q[lvl];
    for (int k = 0; k < MASTERS; k++) begin
      scan = (scan == IW'(MASTERS - 1)) ? '0 : scan + 1'b1;
      if (!found && cand[scan]) begin
        nxt_idx = scan;
        found   = 1'b1;
      end
    end
  end

  // A locked, selected owner is never preempted, even by a starved master.
  assign sw_en = slv_HREADY & can_switch[grant_idx_q] &
                 ~(mstHMASTLOCK[grant_idx_q] & mstHSEL[grant_idx_q]);
  assign take  = sw_en & found;

  always_comb begin
    grant_idx_d = take ? nxt_idx : grant_idx_q;
    granted_d   = '0;
    granted_d[grant_idx_d] = 1'b1;
    ptr_d = ptr_q;
    if (take) ptr_d[lvl] = nxt_idx;
    dph_idx_d = slv_HREADY ? grant_idx_q : dph_idx_q;
    // First beat of a new owner: flagged on the switch edge, dropped once
    // that address phase is accepted.
    if (grant_idx_d != grant_idx_q) fb_d = 1'b1;
    else if (slv_HREADY)            fb_d = 1'b0;
    else                            fb_d = fb_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      grant_idx_q <= '0;
      dph_idx_q   <= '0;
      granted_q   <= MASTERS'(1);
      ptr_q       <= '0;
      fb_q        <= 1'b0;
    end else begin
      grant_idx_q <= grant_idx_d;
      dph_idx_q   <= dph_idx_d;
      granted_q   <= granted_d;
      ptr_q       <= ptr_d;
      fb_q        <= fb_d;
    end

  // Clear uses the next grant so a newly granted master reads 0 straight away.
  assign wc_clr = granted_d | ~mstHSEL;
  assign wc_inc = {MASTERS{slv_HREADY}};

  riscv_slave_port_arb_wcnt #(.LIMIT(STARVE_LIMIT)) u_wcnt [MASTERS-1:0] (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .clr     (wc_clr),
    .inc     (wc_inc),
    .starved (starved)
  );

  assign granted_master = granted_q;

  assign trans_mux     = mstHTRANS[grant_idx_q];
  assign slv_HTRANS    = (fb_q && trans_mux == 2'b11) ? 2'b10 : trans_mux;
  assign slv_HSEL      = mstHSEL[grant_idx_q];
  assign slv_HADDR     = mstHADDR[grant_idx_q];
  assign slv_HWRITE    = mstHWRITE[grant_idx_q];
  assign slv_HSIZE     = mstHSIZE[grant_idx_q];
  assign slv_HBURST    = mstHBURST[grant_idx_q];
  assign slv_HPROT     = mstHPROT[grant_idx_q];
  assign slv_HMASTLOCK = mstHMASTLOCK[grant_idx_q];
  assign slv_HREADYOUT = mstHREADY[grant_idx_q];
  assign slv_HWDATA    = mstHWDATA[dph_idx_q];

  assign mstHRDATA    = slv_HRDATA;
  assign mstHREADYOUT = slv_HREADY;
  assign mstHRESP     = slv_HRESP;
endmodule

// File: tb/tb_riscv_slave_port_arb.sv
// Bench for riscv_slave_port_arb: two instances (priority mode and pure
// round-robin mode) share one stimulus; directed scenarios plus a random run
// against a behavioural model of the arbitration rules.
module tb_riscv_slave_port_arb;
  localparam int M   = 3;
  localparam int PB  = 3;
  localparam int LIM = 16;

  logic HCLK, HRESETn;
  logic [M-1:0][PB-1:0] prio;
  logic [M-1:0]         hsel, hwrite, hlock, hready_m, can_sw;
  logic [M-1:0][63:0]   haddr, hwdata;
  logic [M-1:0][2:0]    hsize, hburst;
  logic [M-1:0][3:0]    hprot;
  logic [M-1:0][1:0]    htrans;
  logic [63:0]          s_hrdata;
  logic                 s_hready, s_hresp;

  logic [1:0][63:0] o_mrdata, o_haddr, o_hwdata;
  logic [1:0]       o_mready, o_mresp, o_hsel, o_hwrite, o_hlock, o_hreadyout;
  logic [1:0][2:0]  o_hsize, o_hburst, o_gm, o_st;
  logic [1:0][3:0]  o_hprot;
  logic [1:0][1:0]  o_htrans;

  int errors = 0;
  int checks = 0;

  // behavioural model state, index [mode]
  int m_g [2];
  int m_d [2];
  int m_fb[2];
  int m_ptr[2][1<<PB];
  int m_cnt[2][M];

  for (genvar i = 0; i < 2; i++) begin : g_dut
    riscv_slave_port_arb #(.PLEN(64), .XLEN(64), .MASTERS(M), .PRIO_BITS(PB),
                           .ARB_MODE(i), .STARVE_LIMIT(LIM)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .mstpriority(prio), .mstHSEL(hsel),
      .mstHADDR(haddr), .mstHWDATA(hwdata), .mstHRDATA(o_mrdata[i]),
      .mstHWRITE(hwrite), .mstHSIZE(hsize), .mstHBURST(hburst), .mstHPROT(hprot),
      .mstHTRANS(htrans), .mstHMASTLOCK(hlock), .mstHREADY(hready_m),
      .mstHREADYOUT(o_mready[i]), .mstHRESP(o_mresp[i]),
      .slv_HSEL(o_hsel[i]), .slv_HADDR(o_haddr[i]), .slv_HWDATA(o_hwdata[i]),
      .slv_HRDATA(s_hrdata), .slv_HWRITE(o_hwrite[i]), .slv_HSIZE(o_hsize[i]),
      .slv_HBURST(o_hburst[i]), .slv_HPROT(o_hprot[i]), .slv_HTRANS(o_htrans[i]),
      .slv_HMASTLOCK(o_hlock[i]), .slv_HREADYOUT(o_hreadyout[i]),
      .slv_HREADY(s_hready), .slv_HRESP(s_hresp), .can_switch(can_sw),
      .granted_master(o_gm[i]), .starved(o_st[i])
    );
  end

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      m_g[md] = 0; m_d[md] = 0; m_fb[md] = 0;
      for (int l = 0; l < (1 << PB); l++) m_ptr[md][l] = 0;
      for (int n = 0; n < M; n++) m_cnt[md][n] = 0;
    end
  endtask

  // One clock edge of the arbitration rules for mode md, using current inputs.
  task automatic model_step(input int md);
    int eff[M];
    int lvl, nx, ng, j;
    bit found, sw;
    lvl = -1; nx = m_g[md]; found = 0;
    for (int n = 0; n < M; n++) begin
      eff[n] = (m_cnt[md][n] >= LIM) ? (1 << PB) - 1 : ((md == 1) ? 0 : int'(prio[n]));
      if (hsel[n] && eff[n] > lvl) lvl = eff[n];
    end
    if (lvl >= 0)
      for (int k = 1; k <= M; k++) begin
        j = (m_ptr[md][lvl] + k) % M;
        if (!found && hsel[j] && eff[j] == lvl) begin nx = j; found = 1; end
      end
    sw = s_hready && can_sw[m_g[md]] && !(hlock[m_g[md]] && hsel[m_g[md]]);
    ng = (sw && found) ? nx : m_g[md];
    if (sw && found) m_ptr[md][lvl] = nx;
    if (ng != m_g[md]) m_fb[md] = 1;
    else if (s_hready) m_fb[md] = 0;
    if (s_hready) m_d[md] = m_g[md];
    for (int n = 0; n < M; n++)
      if (n == ng || !hsel[n]) m_cnt[md][n] = 0;
      else if (s_hready && m_cnt[md][n] < LIM) m_cnt[md][n]++;
    m_g[md] = ng;
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    #2;
    HRESETn = 1'b1;
  endtask

  task automatic set_default();
    prio = '0; hsel = '1; hlock = '0; can_sw = '1; s_hready = 1'b1;
    htrans = {M{2'b10}};
    for (int n = 0; n < M; n++) begin
      haddr[n]  = {$urandom, $urandom};
      hwdata[n] = {$urandom, $urandom};
    end
  endtask

  task automatic test_reset();
    set_default();
    hwrite = '0; hsize = '0; hburst = '0; hprot = '0; hready_m = '1;
    s_hrdata = '0; s_hresp = 1'b0;
    model_reset();
    #1;
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_gm[md] !== 3'b001) begin
        errors++; $display("FAIL reset_grant dut%0d: got %b want 001", md, o_gm[md]);
      end
      checks++;
      if (o_st[md] !== 3'b000) begin
        errors++; $display("FAIL reset_starved dut%0d: got %b want 000", md, o_st[md]);
      end
      checks++;
      if (o_haddr[md] !== haddr[0]) begin
        errors++; $display("FAIL reset_haddr dut%0d: got %h want %h", md, o_haddr[md], haddr[0]);
      end
    end
  endtask

  task automatic test_prio_starve();
    logic [2:0] e0, e1;
    do_reset();
    set_default();
    prio[0] = 3'd1; prio[1] = 3'd5; prio[2] = 3'd5;
    for (int e = 1; e <= 18; e++) begin
      step();
      e0 = (e == 17) ? 3'b001 : (e == 18) ? 3'b010 : ((e % 2 == 1) ? 3'b010 : 3'b100);
      e1 = (e % 3 == 1) ? 3'b010 : ((e % 3 == 2) ? 3'b100 : 3'b001);
      checks++;
      if (o_gm[0] !== e0) begin
        errors++; $display("FAIL prio_grant e%0d: got %b want %b", e, o_gm[0], e0);
      end
      checks++;
      if (o_st[0] !== ((e == 16) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL prio_starved e%0d: got %b want %b", e, o_st[0],
                           (e == 16) ? 3'b001 : 3'b000);
      end
      checks++;
      if (o_gm[1] !== e1) begin
        errors++; $display("FAIL rr_grant e%0d: got %b want %b", e, o_gm[1], e1);
      end
      checks++;
      if (o_st[1] !== 3'b000) begin
        errors++; $display("FAIL rr_starved e%0d: got %b want 000", e, o_st[1]);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    set_default();
    hsel = 3'b101; hlock = 3'b001;
    for (int e = 1; e <= 20; e++) begin
      step();
      for (int md = 0; md < 2; md++) begin
        checks++;
        if (o_gm[md] !== 3'b001) begin
          errors++; $display("FAIL lock_hold dut%0d e%0d: got %b want 001", md, e, o_gm[md]);
        end
      end
    end
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_st[md] !== 3'b100) begin
        errors++; $display("FAIL lock_starved dut%0d: got %b want 100", md, o_st[md]);
      end
    end
    hlock = '0;
    step();
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_gm[md] !== 3'b100) begin
        errors++; $display("FAIL lock_release dut%0d: got %b want 100", md, o_gm[md]);
      end
    end
  endtask

  task automatic test_seq_convert();
    do_reset();
    set_default();
    prio[1] = 3'd5; can_sw = 3'b101; htrans = {M{2'b11}};
    step();
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_gm[md] !== 3'b010 || o_htrans[md] !== 2'b10 || o_hwdata[md] !== hwdata[0]) begin
        errors++; $display("FAIL seq_first dut%0d: got gm=%b tr=%b wd=%h want 010/10/%h",
                           md, o_gm[md], o_htrans[md], o_hwdata[md], hwdata[0]);
      end
    end
    step();
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_gm[md] !== 3'b010 || o_htrans[md] !== 2'b11 || o_hwdata[md] !== hwdata[1]
          || o_haddr[md] !== haddr[1]) begin
        errors++; $display("FAIL seq_next dut%0d: got gm=%b tr=%b wd=%h want 010/11/%h",
                           md, o_gm[md], o_htrans[md], o_hwdata[md], hwdata[1]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_default();
    prio[1] = 3'd5; s_hready = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      for (int md = 0; md < 2; md++) begin
        checks++;
        if (o_gm[md] !== 3'b001 || o_st[md] !== 3'b000 || o_hwdata[md] !== hwdata[0]) begin
          errors++; $display("FAIL stall_hold dut%0d e%0d: got gm=%b st=%b wd=%h", md, e,
                             o_gm[md], o_st[md], o_hwdata[md]);
        end
      end
    end
    s_hready = 1'b1;
    step();
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_gm[md] !== 3'b010) begin
        errors++; $display("FAIL stall_switch dut%0d: got %b want 010", md, o_gm[md]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_default();
    prio[2] = 3'd7; htrans = {M{2'b11}};
    step();
    step();
    checks++;
    if (o_gm[0] !== 3'b100) begin
      errors++; $display("FAIL midrst_pre: got %b want 100", o_gm[0]);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (o_gm[md] !== 3'b001 || o_st[md] !== 3'b000 || o_haddr[md] !== haddr[0]) begin
        errors++; $display("FAIL midrst dut%0d: got gm=%b st=%b addr=%h want 001/000/%h",
                           md, o_gm[md], o_st[md], o_haddr[md], haddr[0]);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [77:0] exp_ac, got_ac;
    logic [2:0]  eg, es;
    logic [1:0]  et;
    int g;
    do_reset();
    set_default();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc % 40 == 0)
        for (int n = 0; n < M; n++) prio[n] = PB'($urandom_range(0, (1 << PB) - 1));
      for (int n = 0; n < M; n++) begin
        hsel[n]     = ($urandom_range(0, 9) != 0);
        hlock[n]    = ($urandom_range(0, 9) == 0);
        can_sw[n]   = ($urandom_range(0, 3) != 0);
        hwrite[n]   = 1'($urandom);
        hready_m[n] = 1'($urandom);
        hsize[n]    = 3'($urandom);
        hburst[n]   = 3'($urandom);
        hprot[n]    = 4'($urandom);
        htrans[n]   = 2'($urandom);
        haddr[n]    = {$urandom, $urandom};
        hwdata[n]   = {$urandom, $urandom};
      end
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = 1'($urandom);
      s_hrdata = {$urandom, $urandom};
      #1;
      for (int md = 0; md < 2; md++) begin
        g  = m_g[md];
        eg = 3'(1 << g);
        for (int n = 0; n < M; n++) es[n] = (m_cnt[md][n] >= LIM);
        et = (m_fb[md] != 0 && htrans[g] == 2'b11) ? 2'b10 : htrans[g];
        exp_ac = {hsel[g], hwrite[g], hlock[g], hready_m[g], haddr[g], hsize[g], hburst[g], hprot[g]};
        got_ac = {o_hsel[md], o_hwrite[md], o_hlock[md], o_hreadyout[md], o_haddr[md],
                  o_hsize[md], o_hburst[md], o_hprot[md]};
        checks++;
        if (o_gm[md] !== eg || o_st[md] !== es) begin
          errors++; $display("FAIL rnd_grant dut%0d c%0d: got gm=%b st=%b want %b/%b",
                             md, cyc, o_gm[md], o_st[md], eg, es);
        end
        checks++;
        if (got_ac !== exp_ac) begin
          errors++; $display("FAIL rnd_ctrl dut%0d c%0d: got %h want %h", md, cyc, got_ac, exp_ac);
        end
        checks++;
        if (o_htrans[md] !== et) begin
          errors++; $display("FAIL rnd_htrans dut%0d c%0d: got %b want %b", md, cyc, o_htrans[md], et);
        end
        checks++;
        if (o_hwdata[md] !== hwdata[m_d[md]]) begin
          errors++; $display("FAIL rnd_hwdata dut%0d c%0d: got %h want %h", md, cyc,
                             o_hwdata[md], hwdata[m_d[md]]);
        end
        checks++;
        if ({o_mrdata[md], o_mready[md], o_mresp[md]} !== {s_hrdata, s_hready, s_hresp}) begin
          errors++; $display("FAIL rnd_resp dut%0d c%0d: got %h/%b/%b want %h/%b/%b", md, cyc,
                             o_mrdata[md], o_mready[md], o_mresp[md], s_hrdata, s_hready, s_hresp);
        end
      end
      step();
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    #6;
    test_reset();
    test_prio_starve();
    test_lock();
    test_seq_convert();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
